// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative carry-save multiply/accumulate sequencer.
package mul_pkg;

    localparam int MUL_W      = 32;
    localparam int MUL_DIGITS = MUL_W / 2 + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        RESOLVE  = 2'd2,
        DONE     = 2'd3
    } mul_state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Radix-4 Booth decode of {b[2i+1], b[2i], b[2i-1]}; sub flips the digit sign.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip, input logic sub);
        booth_digit_t d;
        d.zero = (trip == 3'b000) || (trip == 3'b111);
        d.two  = (trip == 3'b011) || (trip == 3'b100);
        d.neg  = (trip[2] ^ sub) & ~d.zero;
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator for digit idx; negative digits emit ~x and
// raise neg so the caller injects the +1 through the free carry LSB.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int IDX_W = 5
) (
    input  logic [2:0]         triplet,
    input  logic [2*WIDTH-1:0] a_ext,
    input  logic               sub_op,
    input  logic [IDX_W-1:0]   idx,
    output logic [2*WIDTH-1:0] pp,
    output logic               neg
);

    booth_digit_t       dig_s;
    logic [2*WIDTH-1:0] mag_s;
    logic [2*WIDTH-1:0] shifted_s;

    // Select 0/A/2A, align to the digit weight, then conditionally invert.
    always_comb begin
        dig_s = booth_decode(triplet, sub_op);
        mag_s = '0;
        if (dig_s.zero) begin
            mag_s = '0;
        end else if (dig_s.two) begin
            mag_s = {a_ext[2*WIDTH-2:0], 1'b0};
        end else begin
            mag_s = a_ext;
        end
        shifted_s = mag_s << {idx, 1'b0};
        if (dig_s.neg) begin
            pp = ~shifted_s;
        end else begin
            pp = shifted_s;
        end
        neg = dig_s.neg;
    end

endmodule

// File: rtl/csa.sv
// Bit-parallel 3:2 carry-save compressor; carry is returned unshifted.
module csa #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    // Full-adder sum and majority per bit.
    always_comb begin
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
    end

endmodule

// File: rtl/mul_csa_seq.sv
// Iterative MULT/MULTU/MADD(U)/MSUB(U) sequencer: one Booth digit per cycle into a
// carry-save accumulator, then a single carry-propagate add into RESULT.
module mul_csa_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_op,
    input  logic               acc_en,
    input  logic               sub_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic               flush,
    output logic               busy,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int PW     = 2 * WIDTH;
    localparam int DIGITS = (WIDTH == MUL_W) ? MUL_DIGITS : WIDTH / 2 + 1;
    localparam int CNT_W  = $clog2(DIGITS);
    localparam int BW     = WIDTH + 3;

    mul_state_t        state_r;
    mul_state_t        state_s;
    mul_state_t        nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [PW-1:0]     sum_r;
    logic [PW-1:0]     carry_r;
    logic [PW-1:0]     a_ext_r;
    logic [BW-1:0]     b_sh_r;
    logic              sub_r;
    logic [PW-1:0]     result_r;
    logic              busy_r;
    logic              valid_r;

    logic              accept_s;
    logic              last_digit_s;
    logic [PW-1:0]     pp_s;
    logic              neg_s;
    logic [PW-1:0]     carry_in_s;
    logic [PW-1:0]     csa_sum_s;
    logic [PW-1:0]     csa_carry_s;
    logic              b_ext_s;

    assign accept_s     = (state_r == IDLE) && start && !flush;
    assign last_digit_s = (cnt_r == CNT_W'(DIGITS - 1));
    assign b_ext_s      = signed_op & src_b[WIDTH-1];
    assign carry_in_s   = {carry_r[PW-2:0], neg_s};

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_booth_pp_gen (
        .triplet (b_sh_r[2:0]),
        .a_ext   (a_ext_r),
        .sub_op  (sub_r),
        .idx     (cnt_r),
        .pp      (pp_s),
        .neg     (neg_s)
    );

    csa #(
        .W (PW)
    ) u_csa (
        .x (sum_r),
        .y (carry_in_s),
        .z (pp_s),
        .s (csa_sum_s),
        .c (csa_carry_s)
    );

    // Next-state decode; flush overrides every transition.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nxt_s = COMPRESS;
                end else begin
                    nxt_s = IDLE;
                end
            end
            COMPRESS: begin
                if (last_digit_s) begin
                    nxt_s = RESOLVE;
                end else begin
                    nxt_s = COMPRESS;
                end
            end
            RESOLVE: nxt_s = DONE;
            DONE:    nxt_s = IDLE;
            default: nxt_s = IDLE;
        endcase
        state_s = flush ? IDLE : nxt_s;
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            valid_r <= (state_s == DONE);
        end
    end

    // Operand capture at accept and carry-save accumulation during COMPRESS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_r   <= '0;
            carry_r <= '0;
            a_ext_r <= '0;
            b_sh_r  <= '0;
            sub_r   <= 1'b0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            sum_r   <= acc_en ? acc_in : '0;
            carry_r <= '0;
            a_ext_r <= signed_op ? {{WIDTH{src_a[WIDTH-1]}}, src_a}
                                 : {{WIDTH{1'b0}}, src_a};
            b_sh_r  <= {b_ext_s, b_ext_s, src_b, 1'b0};
            sub_r   <= sub_op;
            cnt_r   <= '0;
        end else if (state_r == COMPRESS) begin
            sum_r   <= csa_sum_s;
            carry_r <= csa_carry_s;
            b_sh_r  <= {2'b00, b_sh_r[BW-1:2]};
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Final carry-propagate add; a flush during RESOLVE leaves RESULT untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_r <= '0;
        end else if ((state_r == RESOLVE) && !flush) begin
            result_r <= sum_r + {carry_r[PW-2:0], 1'b0};
        end
    end

    // The DONE pulse is gated by flush so a same-cycle flush cancels it.
    assign busy         = busy_r;
    assign result_valid = valid_r & ~flush;
    assign result       = result_r;

endmodule
